draw_layer_arbiter: RTL

Per-pixel arbiter between the VGA drawing requesters (background, borders, sprites, text) in front of the VGA output stage. Each requester presents a draw request and an 8-bit RGB for the current pixel. The block selects the highest-priority enabled requester and falls back to the background colour when none wins. It also accepts layer-enable reconfiguration through a valid/ready handshake, applied only on a frame boundary, and flags overlaps between layers.

---
 rtl/draw_arb_pkg.sv | 14 +
 rtl/draw_priority_encoder.sv | 25 ++
 rtl/draw_layer_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the VGA draw-layer arbiter.
package draw_arb_pkg;

  typedef logic [7:0] rgb_t;

  localparam int unsigned DEFAULT_NUM_LAYERS = 4;
  localparam rgb_t        RESET_RGB          = 8'h00;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/draw_priority_encoder.sv
// Lowest-set-index priority encoder; index 0 is the highest priority.
module draw_priority_encoder
  import draw_arb_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = DEFAULT_NUM_LAYERS,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [NUM_LAYERS-1:0] req_i,
  output logic                  found_o,
  output logic [IDX_W-1:0]      idx_o
);

  // Scan from the top so the lowest set index is written last and wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/draw_layer_arbiter.sv
// Per-pixel layer arbiter with frame-aligned enable reconfiguration.
// Optional overlap detection is built when COLLISION_DETECT_EN is defined.
module draw_layer_arbiter
  import draw_arb_pkg::*;
#(
  parameter int unsigned NUM_LAYERS    = DEFAULT_NUM_LAYERS,
  parameter int unsigned FRAME_START_X = 0,
  parameter int unsigned FRAME_START_Y = 0,
  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [10:0]                pixelX,
  input  logic [10:0]                pixelY,
  input  logic [NUM_LAYERS-1:0]      drawReq,
  input  logic [NUM_LAYERS-1:0][7:0] layerRGB,
  input  logic [7:0]                 BG_RGB,
  input  logic                       cfg_valid,
  input  logic [NUM_LAYERS-1:0]      cfg_enable,
  output logic                       cfg_ready,
  output logic [7:0]                 RGBOut,
  output logic [IDX_W-1:0]           winnerIdx,
  output logic                       anyDraw,
  output logic                       collision,
  output logic [NUM_LAYERS-1:0]      collisionMask
);

  cfg_state_t            state_q, state_d;
  logic [NUM_LAYERS-1:0] enable_q, enable_d;
  logic [NUM_LAYERS-1:0] pending_q, pending_d;
  logic                  ready_q;
  logic                  frame_start;
  logic [NUM_LAYERS-1:0] eff_mask;
  logic [NUM_LAYERS-1:0] active;
  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  rgb_t                  rgb_q, rgb_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  any_q, any_d;

  assign frame_start = (pixelX == 11'(FRAME_START_X)) && (pixelY == 11'(FRAME_START_Y));

  // A pending mask takes effect on the frame-start pixel itself.
  assign eff_mask = ((state_q == PENDING) && frame_start) ? pending_q : enable_q;
  assign active   = drawReq & eff_mask;

  draw_priority_encoder #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_winner (
    .req_i   (active),
    .found_o (found),
    .idx_o   (win_idx)
  );

  always_comb begin
    rgb_d = found ? layerRGB[win_idx] : BG_RGB;
    idx_d = found ? win_idx : '0;
    any_d = found;
  end

  // Config FSM: capture in IDLE, commit at the next frame start.
  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          pending_d = cfg_enable;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          enable_d = pending_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= IDLE;
      enable_q  <= '1;
      pending_q <= '0;
      ready_q   <= 1'b1;
      rgb_q     <= RESET_RGB;
      idx_q     <= '0;
      any_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      ready_q   <= (state_d == IDLE);
      rgb_q     <= rgb_d;
      idx_q     <= idx_d;
      any_q     <= any_d;
    end
  end

  assign cfg_ready = ready_q;
  assign RGBOut    = rgb_q;
  assign winnerIdx = idx_q;
  assign anyDraw   = any_q;

`ifdef COLLISION_DETECT_EN
  logic                  collide;
  logic [NUM_LAYERS-1:0] hit;
  logic                  coll_q;
  logic [NUM_LAYERS-1:0] cmask_q, cmask_d;

  // Clearing the lowest set bit leaves a residue only when two or more are set.
  assign collide = |(active & (active - NUM_LAYERS'(1)));
  assign hit     = collide ? active : '0;
  assign cmask_d = frame_start ? hit : (cmask_q | hit);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      coll_q  <= 1'b0;
      cmask_q <= '0;
    end else begin
      coll_q  <= collide;
      cmask_q <= cmask_d;
    end
  end

  assign collision     = coll_q;
  assign collisionMask = cmask_q;
`else
  assign collision     = 1'b0;
  assign collisionMask = '0;
`endif

endmodule
